// File: rtl/abs_dtc.sv
// -----------------------------------------------------------------------------
// abs_dtc
//   Sign/magnitude splitter in front of the digital-to-time converter.
//   A two's-complement code is split into its sign bit and its unsigned
//   magnitude. The DTC is driven with the magnitude, and the sign steers the
//   edge polarity downstream. With REG_OUT=1 the results are registered so they
//   line up with the DTC clock domain. With REG_OUT=0 they are combinational.
//
// Parameters
//   WIDTH    bit width of din and dtc_in_unsigned (>= 2)
//   REG_OUT  1: registered outputs (latency 1), 0: combinational (latency 0)
//
// Ports
//   clk              in   1      system clock, rising edge active
//   rst_n            in   1      asynchronous active-low reset
//   din_valid        in   1      din qualifier
//   din              in   WIDTH  signed two's-complement input code
//   dout_valid       out  1      qualifier for din_sign / dtc_in_unsigned
//   din_sign         out  1      1 when din is negative
//   dtc_in_unsigned  out  WIDTH  unsigned magnitude |din|
// -----------------------------------------------------------------------------
module abs_dtc #(
  parameter int WIDTH   = 8,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             dout_valid,
  output logic             din_sign,
  output logic [WIDTH-1:0] dtc_in_unsigned
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             w_sign;
  logic [WIDTH-1:0] w_mag;

  // The negation is kept at WIDTH bits on purpose. The most negative code maps
  // onto itself, and that bit pattern read as unsigned is exactly 2^(WIDTH-1).
  // The full magnitude range therefore fits without an extra bit.
  assign w_sign = din[WIDTH-1];
  assign w_mag  = w_sign ? (~din + ONE) : din;

  if (REG_OUT) begin : g_reg
    logic             r_valid;
    logic             r_sign;
    logic [WIDTH-1:0] r_mag;

    // The data registers load only on valid samples. When din_valid is low they
    // keep their last value, so an idle or X-driven din cannot disturb the
    // outputs. The valid flag follows din_valid on every edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_sign  <= 1'b0;
        r_mag   <= '0;
      end else begin
        r_valid <= din_valid;
        if (din_valid) begin
          r_sign <= w_sign;
          r_mag  <= w_mag;
        end
      end
    end

    assign dout_valid      = r_valid;
    assign din_sign        = r_sign;
    assign dtc_in_unsigned = r_mag;
  end else begin : g_comb
    assign dout_valid      = din_valid;
    assign din_sign        = w_sign;
    assign dtc_in_unsigned = w_mag;
  end

endmodule

// File: tb/tb_abs_dtc.sv
// -----------------------------------------------------------------------------
// tb_abs_dtc
//   Self-checking bench for abs_dtc.
//   It drives three instances:
//     - the default build (WIDTH=8, REG_OUT=1)
//     - a combinational build (REG_OUT=0) that shares the same din
//     - a 4-bit registered build
//   Expected magnitudes come from integer arithmetic in the bench.
// -----------------------------------------------------------------------------
module tb_abs_dtc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din_valid = 1'b0;
  logic [7:0] din = '0;
  logic       dout_valid, din_sign;
  logic [7:0] dtc_in_unsigned;
  logic       c_dout_valid, c_din_sign;
  logic [7:0] c_dtc_in_unsigned;
  logic       din_valid4 = 1'b0;
  logic [3:0] din4 = '0;
  logic       dout_valid4, din_sign4;
  logic [3:0] dtc_in_unsigned4;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  abs_dtc #(.WIDTH(8), .REG_OUT(1'b1)) u_reg (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .dout_valid(dout_valid), .din_sign(din_sign),
    .dtc_in_unsigned(dtc_in_unsigned)
  );

  abs_dtc #(.WIDTH(8), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .dout_valid(c_dout_valid), .din_sign(c_din_sign),
    .dtc_in_unsigned(c_dtc_in_unsigned)
  );

  abs_dtc #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid4), .din(din4),
    .dout_valid(dout_valid4), .din_sign(din_sign4),
    .dtc_in_unsigned(dtc_in_unsigned4)
  );

  typedef struct {
    logic       vld;
    logic [7:0] din;
    logic       eVld;
    logic [7:0] eMag;
    logic       eSign;
  } vec_t;

  vec_t vecs[10];

  // Compares one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else
      passCount++;
  endtask

  // Drives one sample on the falling edge so it settles before the next rising
  // edge.
  task automatic applyStimulus(input logic vld, input logic [7:0] d);
    @(negedge clk);
    din_valid = vld;
    din       = d;
  endtask

  initial begin
    int mag;
    int sv;

    // The table is applied one entry per clock. Each row lists the registered
    // outputs expected one edge after that row's din is driven.
    vecs[0] = '{1'b1, 8'h80, 1'b1, 8'h80, 1'b1};
    vecs[1] = '{1'b1, 8'hFF, 1'b1, 8'h01, 1'b1};
    vecs[2] = '{1'b1, 8'h7F, 1'b1, 8'h7F, 1'b0};
    vecs[3] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 8'h9C, 1'b1, 8'h64, 1'b1};
    vecs[5] = '{1'b0, 8'h12, 1'b0, 8'h64, 1'b1};
    vecs[6] = '{1'b1, 8'h01, 1'b1, 8'h01, 1'b0};
    vecs[7] = '{1'b1, 8'hF6, 1'b1, 8'h0A, 1'b1};
    vecs[8] = '{1'b1, 8'h81, 1'b1, 8'h7F, 1'b1};
    vecs[9] = '{1'b0, 8'h80, 1'b0, 8'h7F, 1'b1};

    // Reset state, checked while reset is asserted and the clock is running.
    din = 8'h9C;
    din_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", {7'b0, dout_valid}, 8'h00);
    checkOutput("reset_sign",  {7'b0, din_sign}, 8'h00);
    checkOutput("reset_mag",   dtc_in_unsigned, 8'h00);
    checkOutput("reset_w4_mag", {4'b0, dtc_in_unsigned4}, 8'h00);
    @(negedge clk);
    din_valid = 1'b0;
    rst_n = 1'b1;

    // Table of directed vectors.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].vld, vecs[i].din);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_valid", i), {7'b0, dout_valid}, {7'b0, vecs[i].eVld});
      checkOutput($sformatf("vec%0d_sign", i),  {7'b0, din_sign}, {7'b0, vecs[i].eSign});
      checkOutput($sformatf("vec%0d_mag", i),   dtc_in_unsigned, vecs[i].eMag);
    end

    // Exhaustive sweep. The combinational build is checked just after the
    // drive, and the registered build one edge later.
    for (int v = -128; v <= 127; v++) begin
      sv  = v;
      mag = (v < 0) ? -v : v;
      applyStimulus(1'b1, sv[7:0]);
      #1;
      checkOutput("comb_valid", {7'b0, c_dout_valid}, 8'h01);
      checkOutput("comb_sign",  {7'b0, c_din_sign}, (v < 0) ? 8'h01 : 8'h00);
      checkOutput("comb_mag",   c_dtc_in_unsigned, mag[7:0]);
      @(posedge clk);
      #1;
      checkOutput("sweep_valid", {7'b0, dout_valid}, 8'h01);
      checkOutput("sweep_sign",  {7'b0, din_sign}, (v < 0) ? 8'h01 : 8'h00);
      checkOutput("sweep_mag",   dtc_in_unsigned, mag[7:0]);
    end

    // The combinational dout_valid tracks din_valid with no latency.
    applyStimulus(1'b0, 8'h05);
    #1;
    checkOutput("comb_valid_low", {7'b0, c_dout_valid}, 8'h00);

    // Valid gap: -3 is captured, then an invalid +50 must leave the data held.
    applyStimulus(1'b1, 8'hFD);
    @(posedge clk);
    #1;
    checkOutput("gap_mag_cap", dtc_in_unsigned, 8'h03);
    applyStimulus(1'b0, 8'd50);
    @(posedge clk);
    #1;
    checkOutput("gap_valid", {7'b0, dout_valid}, 8'h00);
    checkOutput("gap_sign",  {7'b0, din_sign}, 8'h01);
    checkOutput("gap_mag",   dtc_in_unsigned, 8'h03);
    applyStimulus(1'b0, 8'hxx);
    @(posedge clk);
    #1;
    checkOutput("xhold_sign", {7'b0, din_sign}, 8'h01);
    checkOutput("xhold_mag",  dtc_in_unsigned, 8'h03);

    // Mid-stream reset. -100 is captured first. A second -100 is then in
    // flight when reset pulses between edges, and it is replaced by +5 before
    // the next edge.
    applyStimulus(1'b1, 8'h9C);
    @(posedge clk);
    #1;
    checkOutput("rst_pre_mag", dtc_in_unsigned, 8'h64);
    @(negedge clk);
    din = 8'h9C;
    din_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", {7'b0, dout_valid}, 8'h00);
    checkOutput("rst_async_sign",  {7'b0, din_sign}, 8'h00);
    checkOutput("rst_async_mag",   dtc_in_unsigned, 8'h00);
    #1 rst_n = 1'b1;
    din = 8'h05;
    #1;
    checkOutput("rst_released_mag", dtc_in_unsigned, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("rst_after_valid", {7'b0, dout_valid}, 8'h01);
    checkOutput("rst_after_sign",  {7'b0, din_sign}, 8'h00);
    checkOutput("rst_after_mag",   dtc_in_unsigned, 8'h05);

    // 4-bit build boundaries.
    for (int v = -8; v <= 7; v++) begin
      sv  = v;
      mag = (v < 0) ? -v : v;
      @(negedge clk);
      din_valid4 = 1'b1;
      din4 = sv[3:0];
      @(posedge clk);
      #1;
      checkOutput("w4_sign", {7'b0, din_sign4}, (v < 0) ? 8'h01 : 8'h00);
      checkOutput("w4_mag",  {4'b0, dtc_in_unsigned4}, {4'b0, mag[3:0]});
      checkOutput("w4_valid", {7'b0, dout_valid4}, 8'h01);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
